// File: rtl/rc4_swap_ctrl.sv
// rc4_swap_ctrl
//   Sequences one RC4 S-box swap, S[i] <-> S[j], against a single-port
//   8-bit SRAM, using an external temp register to hold old S[i].
//   State order: IDLE, RD_I, LD_TMP, RD_J, WR_I, WR_J, [RD_K, KS], DONE.
//
//   Optional feature macro: RC4_PRGA_KEYSTREAM_EN
//     Defined   : after the swap, S[(S[i]+S[j]) mod 256] is read
//                 (RD_K) and captured into keystream_o (KS).
//     Undefined : RD_K/KS absent; keystream_o and ks_valid_o tie to 0.
//
// Ports
//   clk, rst      clock, asynchronous active-high reset
//   start_i       swap request, sampled in IDLE only
//   i_i, j_i      S-box indices, latched on an accepted start
//   addr_o        SRAM address (0 when no access)
//   ren_o         SRAM read strobe, rdata_i valid the next cycle
//   wen_o         SRAM write strobe, committed at the ending edge
//   wdata_o       SRAM write data (0 when not writing)
//   rdata_i       SRAM read data
//   store_temp_o  load strobe for the external temp register
//   temp_i        current temp register value (old S[i])
//   busy_o        high in every state except IDLE
//   done_o        one-cycle pulse in DONE
//   keystream_o   last PRGA keystream byte
//   ks_valid_o    one-cycle pulse in KS; keystream_o updates at its end
module rc4_swap_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic [7:0] i_i,
  input  logic [7:0] j_i,
  output logic [7:0] addr_o,
  output logic       ren_o,
  output logic       wen_o,
  output logic [7:0] wdata_o,
  input  logic [7:0] rdata_i,
  output logic       store_temp_o,
  input  logic [7:0] temp_i,
  output logic       busy_o,
  output logic       done_o,
  output logic [7:0] keystream_o,
  output logic       ks_valid_o
);

  localparam int DATA_W = 8;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    RD_I   = 4'd1,
    LD_TMP = 4'd2,
    RD_J   = 4'd3,
    WR_I   = 4'd4,
    WR_J   = 4'd5,
`ifdef RC4_PRGA_KEYSTREAM_EN
    RD_K   = 4'd6,
    KS     = 4'd7,
`endif
    DONE   = 4'd8
  } state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] i_q, j_q;
  logic              ks_pulse;

  // Keystream index: carry out of the 8-bit add is discarded.
  function automatic logic [DATA_W-1:0] ks_index(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    logic [DATA_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[DATA_W-1:0];
  endfunction

`ifdef RC4_PRGA_KEYSTREAM_EN
  logic [DATA_W-1:0] sj_q;
  logic [DATA_W-1:0] ks_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      i_q   <= '0;
      j_q   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start_i) begin
        i_q <= i_i;
        j_q <= j_i;
      end
    end
  end

`ifdef RC4_PRGA_KEYSTREAM_EN
  // sj_q keeps S[j] for the keystream index; temp_i still holds old S[i].
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sj_q <= '0;
      ks_q <= '0;
    end else begin
      if (state == WR_I) sj_q <= rdata_i;
      if (state == KS)   ks_q <= rdata_i;
    end
  end

  assign keystream_o = ks_q;
  assign ks_valid_o  = ks_pulse;
`else
  assign keystream_o = '0;
  assign ks_valid_o  = 1'b0;
`endif

  // Outputs decode from state alone, so an asynchronous reset clears
  // every strobe in the same cycle and no further SRAM access is issued.
  always_comb begin
    state_nxt    = state;
    addr_o       = '0;
    ren_o        = 1'b0;
    wen_o        = 1'b0;
    wdata_o      = '0;
    store_temp_o = 1'b0;
    busy_o       = 1'b1;
    done_o       = 1'b0;
    ks_pulse     = 1'b0;
    case (state)
      IDLE: begin
        busy_o = 1'b0;
        if (start_i) state_nxt = RD_I;
      end
      RD_I: begin
        ren_o     = 1'b1;
        addr_o    = i_q;
        state_nxt = LD_TMP;
      end
      LD_TMP: begin
        store_temp_o = 1'b1;
        state_nxt    = RD_J;
      end
      RD_J: begin
        ren_o     = 1'b1;
        addr_o    = j_q;
        state_nxt = WR_I;
      end
      WR_I: begin
        wen_o     = 1'b1;
        addr_o    = i_q;
        wdata_o   = rdata_i;
        state_nxt = WR_J;
      end
      WR_J: begin
        wen_o   = 1'b1;
        addr_o  = j_q;
        wdata_o = temp_i;
`ifdef RC4_PRGA_KEYSTREAM_EN
        state_nxt = RD_K;
`else
        state_nxt = DONE;
`endif
      end
`ifdef RC4_PRGA_KEYSTREAM_EN
      RD_K: begin
        ren_o     = 1'b1;
        addr_o    = ks_index(temp_i, sj_q);
        state_nxt = KS;
      end
      KS: begin
        ks_pulse  = 1'b1;
        state_nxt = DONE;
      end
`endif
      DONE: begin
        done_o    = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        busy_o    = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

`ifndef RC4_PRGA_KEYSTREAM_EN
  // Without the keystream path the pulse has no consumer.
  logic unused_ks;
  assign unused_ks = ks_pulse;
`endif

endmodule

// File: tb/tb_rc4_swap_ctrl.sv
// tb_rc4_swap_ctrl
//   Self-checking bench for rc4_swap_ctrl with a behavioural SRAM and temp
//   register. Expected S-box contents, keystream and done cycle are pushed
//   to a scoreboard when a swap is started and compared on done_o.
module tb_rc4_swap_ctrl;

`ifdef RC4_PRGA_KEYSTREAM_EN
  localparam bit PRGA = 1'b1;
  localparam int LAT  = 8;
`else
  localparam bit PRGA = 1'b0;
  localparam int LAT  = 6;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       start_i;
  logic [7:0] i_i, j_i;
  logic [7:0] addr_o;
  logic       ren_o, wen_o;
  logic [7:0] wdata_o;
  logic [7:0] rdata_i;
  logic       store_temp_o;
  logic [7:0] temp_i;
  logic       busy_o, done_o;
  logic [7:0] keystream_o;
  logic       ks_valid_o;

  rc4_swap_ctrl dut (
    .clk(clk), .rst(rst), .start_i(start_i), .i_i(i_i), .j_i(j_i),
    .addr_o(addr_o), .ren_o(ren_o), .wen_o(wen_o), .wdata_o(wdata_o),
    .rdata_i(rdata_i), .store_temp_o(store_temp_o), .temp_i(temp_i),
    .busy_o(busy_o), .done_o(done_o), .keystream_o(keystream_o),
    .ks_valid_o(ks_valid_o)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM and temp register; preload port used only while idle.
  logic [7:0] mem [256];
  logic [7:0] shadow [256];
  logic       pl_en;
  logic [7:0] pl_addr, pl_data;

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    if (wen_o) mem[addr_o] <= wdata_o;
    if (ren_o) rdata_i <= mem[addr_o];
    if (store_temp_o) temp_i <= rdata_i;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] i, j, si, sj, ks;
    int         done_cyc;
  } exp_t;
  exp_t sb[$];

  int n_vec = 0;
  int n_err = 0;
  int wr_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (ren_o | wen_o | store_temp_o)
        check("strobe_onehot", int'(ren_o) + int'(wen_o) + int'(store_temp_o), 1);
      if (wen_o) wr_cnt <= wr_cnt + 1;
      if (ks_valid_o) begin
        if (sb.size() == 0) check("spurious_ks_valid", 1, 0);
        else check("ks_valid_cycle", cyc, sb[0].done_cyc - 1);
      end
      if (done_o) begin
        if (sb.size() == 0) begin
          check("spurious_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("done_latency", cyc, e.done_cyc);
          check("s_i_after", mem[e.i], e.si);
          check("s_j_after", mem[e.j], e.sj);
          check("busy_in_done", busy_o, 1);
          if (PRGA) check("keystream", keystream_o, e.ks);
          else      check("keystream_zero", {keystream_o, ks_valid_o}, 0);
        end
      end
    end
  end

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    pl_en   = 1'b1;
    pl_addr = a;
    pl_data = d;
    shadow[a] = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic do_swap(input logic [7:0] i, input logic [7:0] j, input bit hold);
    int   t;
    exp_t e;
    logic [7:0] si, sj;
    t = 0;
    @(negedge clk);
    while (busy_o && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (busy_o) begin
      check("idle_timeout", 1, 0);
      return;
    end
    si = shadow[i];
    sj = shadow[j];
    shadow[i] = sj;
    shadow[j] = si;
    e.i = i; e.j = j; e.si = shadow[i]; e.sj = shadow[j];
    e.ks = shadow[8'(si + sj)];
    e.done_cyc = cyc + LAT;
    sb.push_back(e);
    start_i = 1'b1;
    i_i = i;
    j_i = j;
    @(negedge clk);
    if (hold) begin
      t = 0;
      while (!done_o && t < 20) begin
        @(negedge clk);
        t++;
      end
    end
    start_i = 1'b0;
    t = 0;
    while (sb.size() != 0 && t < 30) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      check("done_timeout", 1, 0);
      sb.delete();
    end
  endtask

  initial begin
    int t;
    rst = 1'b1; start_i = 1'b0; i_i = '0; j_i = '0; pl_en = 1'b0;
    pl_addr = '0; pl_data = '0; rdata_i = '0; temp_i = '0;
    repeat (3) @(negedge clk);
    check("rst_outputs", {addr_o, ren_o, wen_o, wdata_o, store_temp_o,
                          busy_o, done_o, keystream_o, ks_valid_o}, 0);
    for (int a = 0; a < 256; a++) preload(8'(a), 8'($urandom_range(0, 255)));
    rst = 1'b0;
    @(negedge clk);
    check("idle_after_rst", {busy_o, ren_o, wen_o, store_temp_o}, 0);

    // Basic swap; 0x11+0x22 points the keystream read at 0x33.
    preload(8'h03, 8'h11);
    preload(8'h07, 8'h22);
    preload(8'h33, 8'hA5);
    do_swap(8'h03, 8'h07, 1'b0);

    // Keystream index wraps: 0xF0+0x20 -> 0x10.
    preload(8'h01, 8'hF0);
    preload(8'h02, 8'h20);
    preload(8'h10, 8'h5C);
    do_swap(8'h01, 8'h02, 1'b0);

    // i == j: contents unchanged, both writes still issued.
    preload(8'h05, 8'h3C);
    @(negedge clk);
    wr_cnt = 0;
    do_swap(8'h05, 8'h05, 1'b0);
    check("self_swap_writes", wr_cnt, 2);
    check("self_swap_value", mem[5], 8'h3C);

    // start_i held through busy: exactly one swap, nothing queued.
    do_swap(8'h08, 8'h09, 1'b1);
    repeat (12) @(negedge clk);
    check("hold_no_restart", busy_o, 0);

    // Random swaps, back to back.
    for (int k = 0; k < 8; k++)
      do_swap(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0);

    // Reset during WR_I aborts with no further write.
    preload(8'h0A, 8'hAA);
    preload(8'h14, 8'hBB);
    start_i = 1'b1; i_i = 8'h0A; j_i = 8'h14;
    @(negedge clk);
    start_i = 1'b0;
    t = 0;
    while (!(wen_o && addr_o == 8'h0A) && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("reach_wr_i", {wen_o, addr_o}, {1'b1, 8'h0A});
    rst = 1'b1;
    #1;
    check("rst_mid_outputs", {addr_o, ren_o, wen_o, wdata_o, store_temp_o,
                              busy_o, done_o, ks_valid_o}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort_s_i", mem[8'h0A], 8'hAA);
    check("abort_s_j", mem[8'h14], 8'hBB);
    check("abort_idle", busy_o, 0);

    // Normal operation resumes after reset.
    do_swap(8'h0A, 8'h14, 1'b0);
    repeat (5) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
